// File: rtl/uart_pkg.sv
// Shared UART types and constants: line configuration enums, receiver FSM states
// and the received-word payload.
package uart_pkg;

    localparam int unsigned UART_MIN_DATA_BITS = 5;
    localparam int unsigned UART_MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_t;

    typedef enum logic {
        STOP_BITS_1 = 1'b0,
        STOP_BITS_2 = 1'b1
    } stop_bits_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP1     = 3'd4,
        S_STOP2     = 3'd5,
        S_WAIT_HIGH = 3'd6
    } rx_os_state_t;

    // Received word plus its status, loaded into the holding register as one unit
    typedef struct packed {
        logic [UART_MAX_DATA_BITS-1:0] data;
        logic                          parity_err;
        logic                          frame_err;
        logic                          brk;
    } rx_word_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous rx pin; flops reset to the
// idle-high line level so reset never looks like a start bit.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling on baud_tick, configurable frame
// format, parity/framing/break/overrun detection and a one-entry valid/ready output.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_tick,
    input  logic                     rx,
    input  logic [3:0]               num_data_bits,
    input  stop_bits_t               stop_bits,
    input  parity_t                  parity,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     rx_parity_err,
    output logic                     rx_frame_err,
    output logic                     rx_break,
    output logic                     rx_overrun,
    output logic                     rx_busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0] N_MIN = 4'(UART_MIN_DATA_BITS);
    localparam logic [3:0] N_MAX = 4'(MAX_DATA_BITS);

    logic rx_s;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .rx_s(rx_s)
    );

    rx_os_state_t             state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]               n_q, n_d;
    logic                     stop2_q, stop2_d;
    parity_t                  par_mode_q, par_mode_d;
    logic                     par_acc_q, par_acc_d;
    logic                     perr_q, perr_d;
    logic                     ferr_q, ferr_d;
    logic                     zero_q, zero_d;

    logic                     done_c;
    logic                     ferr_now_c;
    logic [3:0]               n_clamp_c;
    logic [3:0]               shamt_c;
    logic [MAX_DATA_BITS-1:0] aligned_c;
    rx_word_t                 word_c;
    logic                     accept_c;

    rx_word_t                 hold_q;

    always_comb begin
        if (num_data_bits < N_MIN) begin
            n_clamp_c = N_MIN;
        end else if (num_data_bits > N_MAX) begin
            n_clamp_c = N_MAX;
        end else begin
            n_clamp_c = num_data_bits;
        end
    end

    // Frame sequencing; every transition is gated by baud_tick
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        n_d        = n_q;
        stop2_d    = stop2_q;
        par_mode_d = par_mode_q;
        par_acc_d  = par_acc_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        zero_d     = zero_q;
        done_c     = 1'b0;
        ferr_now_c = ferr_q | ~rx_s;

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d    = S_START;
                        cnt_d      = '0;
                        n_d        = n_clamp_c;
                        stop2_d    = (stop_bits == STOP_BITS_2);
                        par_mode_d = parity;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        if (rx_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_DATA;
                            cnt_d     = '0;
                            bit_cnt_d = '0;
                            shreg_d   = '0;
                            par_acc_d = 1'b0;
                            perr_d    = 1'b0;
                            ferr_d    = 1'b0;
                            zero_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_END) begin
                        cnt_d     = '0;
                        shreg_d   = {rx_s, shreg_q[MAX_DATA_BITS-1:1]};
                        par_acc_d = par_acc_q ^ rx_s;
                        zero_d    = zero_q & ~rx_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if ((bit_cnt_q + 4'd1) == n_q) begin
                            state_d = (par_mode_q != PARITY_NONE) ? S_PARITY : S_STOP1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_q == CNT_END) begin
                        cnt_d   = '0;
                        perr_d  = (par_mode_q == PARITY_ODD) ? ~(par_acc_q ^ rx_s)
                                                             : (par_acc_q ^ rx_s);
                        zero_d  = zero_q & ~rx_s;
                        state_d = S_STOP1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STOP1: begin
                    if (cnt_q == CNT_END) begin
                        cnt_d  = '0;
                        ferr_d = ferr_now_c;
                        zero_d = zero_q & ~rx_s;
                        if (stop2_q) begin
                            state_d = S_STOP2;
                        end else begin
                            done_c  = 1'b1;
                            state_d = ferr_now_c ? S_WAIT_HIGH : S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STOP2: begin
                    if (cnt_q == CNT_END) begin
                        cnt_d   = '0;
                        ferr_d  = ferr_now_c;
                        done_c  = 1'b1;
                        state_d = ferr_now_c ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            n_q        <= N_MIN;
            stop2_q    <= 1'b0;
            par_mode_q <= PARITY_NONE;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            n_q        <= n_d;
            stop2_q    <= stop2_d;
            par_mode_q <= par_mode_d;
            par_acc_q  <= par_acc_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
        end
    end

    // Data was shifted in from the MSB end; right-align it to the frame length
    always_comb begin
        shamt_c           = N_MAX - n_q;
        aligned_c         = shreg_q >> shamt_c;
        word_c.data       = UART_MAX_DATA_BITS'(aligned_c);
        word_c.parity_err = perr_q;
        word_c.frame_err  = ferr_d;
        word_c.brk        = zero_d;
    end

    assign accept_c = rx_valid & rx_ready;

    // One-entry holding register; a same-clk accept frees the slot for a completing frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_overrun <= done_c & rx_valid & ~accept_c;
            rx_busy    <= (state_d != S_IDLE);
            if (done_c && (!rx_valid || accept_c)) begin
                hold_q   <= word_c;
                rx_valid <= 1'b1;
            end else if (accept_c) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data       = hold_q.data[MAX_DATA_BITS-1:0];
    assign rx_parity_err = hold_q.parity_err;
    assign rx_frame_err  = hold_q.frame_err;
    assign rx_break      = hold_q.brk;

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised self-checking bench for uart_rx_os: serial frames are built from the
// frame rules and every delivered word is compared with a queued expectation.
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int OS   = 16;
    localparam int MAXB = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            baud_tick = 1'b0;
    logic            rx = 1'b1;
    logic [3:0]      num_data_bits = 4'd8;
    stop_bits_t      stop_bits = STOP_BITS_1;
    parity_t         parity = PARITY_NONE;
    logic [MAXB-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ready = 1'b1;
    logic            rx_parity_err;
    logic            rx_frame_err;
    logic            rx_break;
    logic            rx_overrun;
    logic            rx_busy;

    uart_rx_os #(
        .OVERSAMPLE   (OS),
        .MAX_DATA_BITS(MAXB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .rx           (rx),
        .num_data_bits(num_data_bits),
        .stop_bits    (stop_bits),
        .parity       (parity),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_break     (rx_break),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    typedef struct {
        int data;
        bit perr;
        bit ferr;
        bit brk;
        int tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tk_seen = 0;
    bit   last_pos_tick = 1'b0;
    int   ovr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    initial forever #5 clk = ~clk;

    // baud_tick every 4th clk, changed just after the edge
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c++;
            baud_tick = (c % 4 == 0);
        end
    end

    initial forever begin
        @(posedge clk);
        last_pos_tick = baud_tick;
        if (baud_tick) tk_seen++;
    end

    // Output monitor: every new word must match the oldest expectation
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_overrun) ovr_cnt++;
            if (rx_valid && !prev) begin
                check("word_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("data", 32'(rx_data), 32'(e.data));
                    check("parity_err", 32'(rx_parity_err), 32'(e.perr));
                    check("frame_err", 32'(rx_frame_err), 32'(e.ferr));
                    check("break", 32'(rx_break), 32'(e.brk));
                    check("done_tick", 32'(tk_seen), 32'(e.tick));
                    check("latency_1clk", 32'(last_pos_tick), 32'd1);
                end
            end
            prev = rx_valid;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d words pending expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!baud_tick);
        end
        #2;
    endtask

    // Drive one frame starting right after a tick; the line is left at the last stop level
    task automatic send_frame(input int data, input int nb_in, input parity_t par,
                              input stop_bits_t sb, input bit flip_par,
                              input bit [1:0] stop_vals, input bit expect_word);
        int   nb;
        int   d;
        int   nbits_after;
        bit   pbit;
        bit   x;
        bit   bits[$];
        exp_t e;
        num_data_bits = 4'(nb_in);
        parity        = par;
        stop_bits     = sb;
        nb = (nb_in < 5) ? 5 : (nb_in > MAXB) ? MAXB : nb_in;
        d  = data & ((1 << nb) - 1);
        pbit = ($countones(d) % 2 == 1) ^ (par == PARITY_ODD) ^ flip_par;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(((d >> i) & 1) == 1);
        if (par != PARITY_NONE) bits.push_back(pbit);
        bits.push_back(stop_vals[0]);
        if (sb == STOP_BITS_2) bits.push_back(stop_vals[1]);
        nbits_after = bits.size() - 1;
        x = ($countones(d) % 2 == 1) ^ pbit;
        e.data = d;
        e.perr = (par == PARITY_ODD) ? (x == 1'b0) : (par == PARITY_EVEN) ? (x == 1'b1) : 1'b0;
        e.ferr = (stop_vals[0] == 1'b0) || (sb == STOP_BITS_2 && stop_vals[1] == 1'b0);
        e.brk  = (d == 0) && (par == PARITY_NONE || pbit == 1'b0) && (stop_vals[0] == 1'b0);
        e.tick = tk_seen + 1 + OS / 2 + OS * nbits_after;
        if (expect_word) exp_q.push_back(e);
        for (int i = 0; i < bits.size(); i++) begin
            rx = bits[i];
            wait_ticks(OS);
            if (i == 0) begin
                // mid-frame configuration changes must be ignored
                num_data_bits = 4'($urandom_range(0, 15));
                parity        = parity_t'($urandom_range(0, 2));
                stop_bits     = stop_bits_t'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        wait_ticks(OS * nbits);
    endtask

    initial begin
        int ovr0;
        int t0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_flags", {28'd0, rx_parity_err, rx_frame_err, rx_break, rx_overrun}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(1);

        // 8N1 back-to-back
        send_frame(32'h55, 8, PARITY_NONE, STOP_BITS_1, 1'b0, 2'b11, 1'b1);
        send_frame(32'hA3, 8, PARITY_NONE, STOP_BITS_1, 1'b0, 2'b11, 1'b1);
        idle(2);

        // 7E2 with a wrong parity bit
        send_frame(32'h3C, 7, PARITY_EVEN, STOP_BITS_2, 1'b1, 2'b11, 1'b1);
        idle(2);

        // start glitch: low for 5 ticks
        rx = 1'b0;
        wait_ticks(5);
        rx = 1'b1;
        check("glitch_busy", 32'(rx_busy), 32'd1);
        wait_ticks(8);
        check("glitch_idle", 32'(rx_busy), 32'd0);
        idle(2);

        // 9-bit 0x1FF with a bad stop bit, line held low afterwards
        send_frame(32'h1FF, 9, PARITY_NONE, STOP_BITS_1, 1'b0, 2'b00, 1'b1);
        wait_ticks(OS);
        check("wait_high_busy", 32'(rx_busy), 32'd1);
        idle(1);
        check("wait_high_released", 32'(rx_busy), 32'd0);
        idle(1);

        // break: line low for three 8N1 frame times
        num_data_bits = 4'd8;
        parity        = PARITY_NONE;
        stop_bits     = STOP_BITS_1;
        rx = 1'b0;
        t0 = tk_seen;
        exp_q.push_back('{data: 0, perr: 1'b0, ferr: 1'b1, brk: 1'b1, tick: t0 + 1 + OS / 2 + OS * 9});
        wait_ticks(3 * 10 * OS);
        check("break_busy", 32'(rx_busy), 32'd1);
        idle(2);
        check("break_released", 32'(rx_busy), 32'd0);
        send_frame(32'h5A, 8, PARITY_ODD, STOP_BITS_1, 1'b0, 2'b11, 1'b1);
        idle(2);

        // randomised frames
        for (int k = 0; k < 30; k++) begin
            bit [1:0] sv;
            stop_bits_t sb;
            sb = stop_bits_t'($urandom_range(0, 1));
            sv = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            send_frame(int'($urandom_range(0, 511)), int'($urandom_range(3, 12)),
                       parity_t'($urandom_range(0, 2)), sb,
                       ($urandom_range(0, 3) == 0), sv, 1'b1);
            if (rx == 1'b0) idle(1);
            else idle(int'($urandom_range(0, 1)));
        end
        idle(2);
        check("no_overrun_yet", 32'(ovr_cnt), 32'd0);

        // overrun with the consumer stalled
        rx_ready = 1'b0;
        ovr0 = ovr_cnt;
        send_frame(32'h11, 8, PARITY_NONE, STOP_BITS_1, 1'b0, 2'b11, 1'b1);
        send_frame(32'h22, 8, PARITY_NONE, STOP_BITS_1, 1'b0, 2'b11, 1'b0);
        idle(2);
        check("overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
        check("held_valid", 32'(rx_valid), 32'd1);
        check("held_data", 32'(rx_data), 32'h011);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("consumed", 32'(rx_valid), 32'd0);

        // reset in the middle of a frame
        rx = 1'b0;
        wait_ticks(40);
        check("midframe_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(rx_valid), 32'd0);
        check("rst_mid_data", 32'(rx_data), 32'd0);
        check("rst_mid_busy", 32'(rx_busy), 32'd0);
        check("rst_mid_flags", {28'd0, rx_parity_err, rx_frame_err, rx_break, rx_overrun}, 32'd0);
        rx = 1'b1;
        wait_ticks(2);
        rst = 1'b0;
        wait_ticks(OS * 3);
        check("post_rst_valid", 32'(rx_valid), 32'd0);
        check("post_rst_busy", 32'(rx_busy), 32'd0);
        check("words_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
